nand_op_sequencer: RTL and testbench



---
 rtl/nand_op_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_nand_op_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/nand_op_sequencer.sv
// rtl/nand_op_sequencer.sv - bit-serial NAND/INV/AND/OR/XOR unit built on one shared NAND gate
// Each cycle runs one NAND micro-op, walking bits from the LSB to the MSB.

module nand_gate (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = ~(i_a & i_b);
endmodule

module nand_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;
  typedef enum logic [1:0] {DST_T, DST_U, DST_V, DST_R} dst_t;

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [BW-1:0]   r_bit;
  logic [1:0]      r_step;
  logic            r_t;
  logic            r_u;
  logic            r_v;
  logic [WIDTH-1:0] r_result;
  logic            r_err;

  logic            w_x;
  logic            w_y;
  logic            w_in_a;
  logic            w_in_b;
  logic            w_nand;
  dst_t            w_dst;
  logic [1:0]      w_last_idx;
  logic            w_last_step;
  logic            w_last_bit;
  logic            w_accept;

  nand_gate u_nand (
    .i_a (w_in_a),
    .i_b (w_in_b),
    .o_y (w_nand)
  );

  assign w_x         = r_a[r_bit];
  assign w_y         = r_b[r_bit];
  assign w_accept    = start_valid && (r_state == ST_IDLE);
  assign w_last_step = (r_step == w_last_idx);
  assign w_last_bit  = (r_bit == BW'(WIDTH - 1));

  // Micro-op table: which operands feed the shared gate and where its output lands.
  always_comb begin
    w_in_a     = 1'b0;
    w_in_b     = 1'b0;
    w_dst      = DST_R;
    w_last_idx = 2'd0;
    case (r_op)
      3'd0: begin
        w_in_a = w_x; w_in_b = w_y;
      end
      3'd1: begin
        w_in_a = w_x; w_in_b = w_x;
      end
      3'd2: begin
        w_last_idx = 2'd1;
        if (r_step == 2'd0) begin
          w_in_a = w_x; w_in_b = w_y; w_dst = DST_T;
        end else begin
          w_in_a = r_t; w_in_b = r_t;
        end
      end
      3'd3: begin
        w_last_idx = 2'd2;
        case (r_step)
          2'd0:    begin w_in_a = w_x; w_in_b = w_x; w_dst = DST_T; end
          2'd1:    begin w_in_a = w_y; w_in_b = w_y; w_dst = DST_U; end
          default: begin w_in_a = r_t; w_in_b = r_u; end
        endcase
      end
      3'd4: begin
        w_last_idx = 2'd3;
        case (r_step)
          2'd0:    begin w_in_a = w_x; w_in_b = w_y; w_dst = DST_T; end
          2'd1:    begin w_in_a = w_x; w_in_b = r_t; w_dst = DST_U; end
          2'd2:    begin w_in_a = w_y; w_in_b = r_t; w_dst = DST_V; end
          default: begin w_in_a = r_u; w_in_b = r_v; end
        endcase
      end
      default: begin
        w_last_idx = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Illegal ops spend one cycle in EXEC so the error response has a one-cycle latency.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_EXEC;
      ST_EXEC: if (r_err || (w_last_step && w_last_bit)) w_next = ST_DONE;
      ST_DONE: if (result_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 3'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_bit    <= '0;
      r_step   <= 2'd0;
      r_t      <= 1'b0;
      r_u      <= 1'b0;
      r_v      <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op     <= op;
            r_a      <= a;
            r_b      <= b;
            r_bit    <= '0;
            r_step   <= 2'd0;
            r_t      <= 1'b0;
            r_u      <= 1'b0;
            r_v      <= 1'b0;
            r_result <= '0;
            r_err    <= (op > 3'd4);
          end
        end
        ST_EXEC: begin
          if (!r_err) begin
            case (w_dst)
              DST_T:   r_t <= w_nand;
              DST_U:   r_u <= w_nand;
              DST_V:   r_v <= w_nand;
              default: r_result[r_bit] <= w_nand;
            endcase
            if (w_last_step) begin
              r_step <= 2'd0;
              if (!w_last_bit) r_bit <= r_bit + 1'b1;
            end else begin
              r_step <= r_step + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign start_ready  = (r_state == ST_IDLE);
  assign result_valid = (r_state == ST_DONE);
  assign busy         = (r_state != ST_IDLE);
  assign result       = r_result;
  assign err          = r_err;

endmodule

// File: tb/tb_nand_op_sequencer.sv
// tb/tb_nand_op_sequencer.sv - directed table-driven bench for nand_op_sequencer

module tb_nand_op_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_valid;
  logic       start_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       result_valid;
  logic       result_ready;
  logic [7:0] result;
  logic       err;
  logic       busy;

  int n_pass = 0;
  int n_total = 0;

  nand_op_sequencer #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op           (op),
    .a            (a),
    .b            (b),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .err          (err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_result;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Issues a command then counts edges until result_valid; assumes we sit at posedge+1.
  task automatic run_cmd(input logic [2:0] c_op, input logic [7:0] c_a, input logic [7:0] c_b,
                         input bit scramble, output int lat);
    start_valid = 1'b1; op = c_op; a = c_a; b = c_b;
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = 0;
    while (!result_valid && lat < 200) begin
      if (scramble) begin
        op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    vecs[0] = '{3'd0, 8'hF0, 8'hCC, 8'h3F, 1'b0, 8};
    vecs[1] = '{3'd4, 8'hA5, 8'h0F, 8'hAA, 1'b0, 32};
    vecs[2] = '{3'd3, 8'h81, 8'h18, 8'h99, 1'b0, 24};
    vecs[3] = '{3'd2, 8'h3C, 8'h0F, 8'h0C, 1'b0, 16};
    vecs[4] = '{3'd1, 8'h00, 8'h5A, 8'hFF, 1'b0, 8};
    vecs[5] = '{3'd5, 8'h12, 8'h34, 8'h00, 1'b1, 1};
    vecs[6] = '{3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1, 1};

    rst_n = 1'b0; start_valid = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00; result_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_start_ready", 32'(start_ready), 32'd1);
    check("reset_result_valid", 32'(result_valid), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].exp_result));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      @(posedge clk); #1;
      check($sformatf("vec%0d_ready_after", i), 32'(start_ready), 32'd1);
    end

    // Backpressure with a rejected command attempt while DONE is held.
    result_ready = 1'b0;
    run_cmd(3'd2, 8'hFF, 8'h55, 1'b0, lat);
    check("bp_latency", 32'(lat), 32'd16);
    start_valid = 1'b1; op = 3'd0; a = 8'h00; b = 8'h00;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      start_valid = 1'b0;
      check($sformatf("bp%0d_result", c), 32'(result), 32'h55);
      check($sformatf("bp%0d_valid", c), 32'(result_valid), 32'd1);
      check($sformatf("bp%0d_busy", c), 32'(busy), 32'd1);
      check($sformatf("bp%0d_start_ready", c), 32'(start_ready), 32'd0);
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_pulse_not_accepted", 32'(busy), 32'd0);

    // Inputs scrambled every cycle during an XOR.
    run_cmd(3'd4, 8'hA5, 8'h0F, 1'b1, lat);
    check("scr_latency", 32'(lat), 32'd32);
    check("scr_result", 32'(result), 32'hAA);
    check("scr_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an XOR.
    start_valid = 1'b1; op = 3'd4; a = 8'hA5; b = 8'h0F;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_start_ready", 32'(start_ready), 32'd1);
    check("mid_rst_valid", 32'(result_valid), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmd(3'd0, 8'hFF, 8'hFF, 1'b0, lat);
    check("post_rst_latency", 32'(lat), 32'd8);
    check("post_rst_result", 32'(result), 32'h00);
    check("post_rst_err", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
